// File: rtl/seg_move_pkg.sv
// Shared types and constants for the segment-walk game: state codes, segment
// and direction indices, reset values and the move adjacency table.
package seg_move_pkg;

  typedef enum logic [1:0] {
    ST_INITIAL = 2'd0,
    ST_MOVING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_WIN     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  localparam logic [2:0] RESET_HEAD    = SEG_G;
  localparam logic [6:0] RESET_VISITED = 7'b1000000;
  localparam logic [6:0] VISITED_ALL   = 7'h7F;
  localparam logic [6:0] SEG_BLANK     = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON    = 7'h00;

  // Returns {legal, target}; target is meaningless when legal is 0.
  function automatic logic [3:0] move_lookup(input logic [2:0] head, input dir_e dir);
    logic [3:0] res;
    res = {1'b0, head};
    case (head)
      SEG_A: case (dir)
        DIR_R:   res = {1'b1, SEG_B};
        DIR_L:   res = {1'b1, SEG_F};
        default: res = {1'b0, head};
      endcase
      SEG_B: case (dir)
        DIR_U:   res = {1'b1, SEG_A};
        DIR_D:   res = {1'b1, SEG_C};
        DIR_L:   res = {1'b1, SEG_G};
        default: res = {1'b0, head};
      endcase
      SEG_C: case (dir)
        DIR_U:   res = {1'b1, SEG_B};
        DIR_D:   res = {1'b1, SEG_D};
        DIR_L:   res = {1'b1, SEG_G};
        default: res = {1'b0, head};
      endcase
      SEG_D: case (dir)
        DIR_R:   res = {1'b1, SEG_C};
        DIR_L:   res = {1'b1, SEG_E};
        default: res = {1'b0, head};
      endcase
      SEG_E: case (dir)
        DIR_U:   res = {1'b1, SEG_F};
        DIR_D:   res = {1'b1, SEG_D};
        DIR_R:   res = {1'b1, SEG_G};
        default: res = {1'b0, head};
      endcase
      SEG_F: case (dir)
        DIR_U:   res = {1'b1, SEG_A};
        DIR_D:   res = {1'b1, SEG_E};
        DIR_R:   res = {1'b1, SEG_G};
        default: res = {1'b0, head};
      endcase
      SEG_G: case (dir)
        DIR_U:   res = {1'b1, SEG_A};
        DIR_D:   res = {1'b1, SEG_D};
        DIR_L:   res = {1'b1, SEG_F};
        DIR_R:   res = {1'b1, SEG_B};
      endcase
      default: res = {1'b0, head};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_tick_timer.sv
// Clearable up-counter; tc_o fires on the enabled cycle where the count equals
// last_i, and the counter returns to zero on that same edge.
module seg_tick_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_20,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_move_ctrl.sv
// Segment-walk game controller: the player steers a head around a 7-segment
// digit, must visit every segment once, and falls back to the start on a bad move.
module seg_move_ctrl
  import seg_move_pkg::*;
#(
  parameter int unsigned INIT_TICKS  = 286,
  parameter int unsigned FALL_TICKS  = 48,
  parameter int unsigned BLINK_TICKS = 24
) (
  input  logic       clk_20,
  input  logic       rst,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [6:0] seg_n,
  output logic [2:0] head,
  output logic [6:0] visited,
  output logic [1:0] state_out
);

  localparam int unsigned STATE_MAX = (INIT_TICKS > FALL_TICKS) ? INIT_TICKS : FALL_TICKS;
  localparam int unsigned STATE_W   = (STATE_MAX > 1) ? $clog2(STATE_MAX) : 1;
  localparam int unsigned BLINK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  state_e     state_q, state_d;
  logic [2:0] head_q, head_d;
  logic [6:0] visited_q, visited_d;
  logic       phase_q, phase_d;
  logic [6:0] seg_n_q, seg_n_d;

  logic       state_tc, blink_tc, blink_clr, move_ok, any_btn;
  dir_e       dir;
  logic [3:0] lookup;
  logic [STATE_W-1:0] state_last;

  // One shared timer covers both INITIAL and FALLING; it restarts on every state change.
  assign state_last = (state_q == ST_FALLING) ? STATE_W'(FALL_TICKS - 1) : STATE_W'(INIT_TICKS - 1);

  seg_tick_timer #(.WIDTH(STATE_W)) u_state_timer (
    .clk_20 (clk_20),
    .rst    (rst),
    .clr_i  (state_d != state_q),
    .en_i   ((state_q == ST_INITIAL) || (state_q == ST_FALLING)),
    .last_i (state_last),
    .tc_o   (state_tc)
  );

  // Held cleared outside MOVING, so entering MOVING always starts a fresh half-period.
  assign blink_clr = move_ok || (state_q != ST_MOVING);

  seg_tick_timer #(.WIDTH(BLINK_W)) u_blink_timer (
    .clk_20 (clk_20),
    .rst    (rst),
    .clr_i  (blink_clr),
    .en_i   (state_q == ST_MOVING),
    .last_i (BLINK_W'(BLINK_TICKS - 1)),
    .tc_o   (blink_tc)
  );

  always_comb begin
    any_btn = btn_right | btn_left | btn_up | btn_down;
    dir     = DIR_D;
    if (btn_right)     dir = DIR_R;
    else if (btn_left) dir = DIR_L;
    else if (btn_up)   dir = DIR_U;
  end

  assign lookup = move_lookup(head_q, dir);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    visited_d = visited_q;
    move_ok   = 1'b0;
    case (state_q)
      ST_INITIAL: if (state_tc) state_d = ST_MOVING;
      ST_MOVING: begin
        if (any_btn) begin
          if (lookup[3] && !visited_q[lookup[2:0]]) begin
            move_ok   = 1'b1;
            head_d    = lookup[2:0];
            visited_d = visited_q | (7'b1 << lookup[2:0]);
            if (visited_d == VISITED_ALL) state_d = ST_WIN;
          end else begin
            state_d = ST_FALLING;
          end
        end
      end
      ST_FALLING: begin
        if (state_tc) begin
          state_d   = ST_INITIAL;
          head_d    = RESET_HEAD;
          visited_d = RESET_VISITED;
        end
      end
      default: state_d = ST_WIN;
    endcase
  end

  always_comb begin
    phase_d = blink_clr ? 1'b0 : (phase_q ^ blink_tc);
    case (state_q)
      ST_INITIAL: seg_n_d = ~visited_q;
      ST_MOVING:  seg_n_d = ~visited_q | (phase_q ? (7'b1 << head_q) : 7'h00);
      ST_FALLING: seg_n_d = SEG_BLANK;
      default:    seg_n_d = SEG_ALL_ON;
    endcase
  end

  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INITIAL;
      head_q    <= RESET_HEAD;
      visited_q <= RESET_VISITED;
      phase_q   <= 1'b0;
      seg_n_q   <= ~RESET_VISITED;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      visited_q <= visited_d;
      phase_q   <= phase_d;
      seg_n_q   <= seg_n_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign head      = head_q;
  assign visited   = visited_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_seg_move_ctrl.sv
// Bench for seg_move_ctrl: directed scenarios with literal expectations plus
// randomized button traffic compared every cycle against a game-rule model.
module tb_seg_move_ctrl;

  localparam int INIT  = 4;
  localparam int FALL  = 3;
  localparam int BLINK = 2;

  logic       clk_20    = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_right = 1'b0;
  logic       btn_left  = 1'b0;
  logic       btn_up    = 1'b0;
  logic       btn_down  = 1'b0;
  logic [6:0] seg_n;
  logic [2:0] head;
  logic [6:0] visited;
  logic [1:0] state_out;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  seg_move_ctrl #(
    .INIT_TICKS  (INIT),
    .FALL_TICKS  (FALL),
    .BLINK_TICKS (BLINK)
  ) dut (
    .clk_20    (clk_20),
    .rst       (rst),
    .btn_right (btn_right),
    .btn_left  (btn_left),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .seg_n     (seg_n),
    .head      (head),
    .visited   (visited),
    .state_out (state_out)
  );

  initial forever #5 clk_20 = ~clk_20;

  // Game model: state 0..3, neighbour table indexed [segment][R,L,U,D], -1 = no edge.
  typedef struct {
    int         st;
    int         hd;
    logic [6:0] vis;
    int         cnt;
    int         bcnt;
    bit         ph;
    logic [6:0] seg;
  } model_t;

  int nbr [7][4] = '{'{1, 5, -1, -1}, '{-1, 6, 0, 2}, '{-1, 6, 1, 3}, '{2, 4, -1, -1},
                     '{6, -1, 5, 3}, '{6, -1, 0, 4}, '{1, 5, 0, 3}};

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.hd = 6; r.vis = 7'h40; r.cnt = 0; r.bcnt = 0; r.ph = 1'b0; r.seg = 7'b0111111;
    return r;
  endfunction

  function automatic logic [6:0] display(model_t c);
    logic [6:0] img;
    case (c.st)
      0:       img = ~c.vis;
      1:       img = c.ph ? (~c.vis | (7'h01 << c.hd)) : ~c.vis;
      2:       img = 7'h7F;
      default: img = 7'h00;
    endcase
    return img;
  endfunction

  function automatic model_t model_next(model_t c, logic [3:0] b);
    model_t n;
    int d;
    int t;
    n = c;
    n.seg = display(c);
    case (c.st)
      0: begin
        if (c.cnt == INIT - 1) begin
          n.st = 1; n.cnt = 0; n.ph = 1'b0; n.bcnt = 0;
        end else n.cnt = c.cnt + 1;
      end
      1: begin
        d = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : b[0] ? 3 : -1;
        if (d < 0) begin
          if (c.bcnt == BLINK - 1) begin
            n.ph = !c.ph; n.bcnt = 0;
          end else n.bcnt = c.bcnt + 1;
        end else begin
          t = nbr[c.hd][d];
          if (t >= 0 && !c.vis[t]) begin
            n.hd = t; n.vis = c.vis | (7'h01 << t); n.ph = 1'b0; n.bcnt = 0;
            if (n.vis == 7'h7F) n.st = 3;
          end else begin
            n.st = 2; n.cnt = 0;
          end
        end
      end
      2: begin
        if (c.cnt == FALL - 1) begin
          n.st = 0; n.cnt = 0; n.hd = 6; n.vis = 7'h40;
        end else n.cnt = c.cnt + 1;
      end
      default: n.st = 3;
    endcase
    return n;
  endfunction

  initial forever begin
    @(posedge clk_20 or posedge rst);
    if (rst) m = model_reset();
    else     m = model_next(m, {btn_right, btn_left, btn_up, btn_down});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk_20);
    if (cmp_en) begin
      chk("model state", 32'(state_out), 32'(m.st));
      chk("model head", 32'(head), 32'(m.hd));
      chk("model visited", 32'(visited), 32'(m.vis));
      chk("model seg_n", 32'(seg_n), 32'(m.seg));
    end
  end

  task automatic pulse(input logic [3:0] b);
    {btn_right, btn_left, btn_up, btn_down} = b;
    @(negedge clk_20);
    {btn_right, btn_left, btn_up, btn_down} = 4'b0000;
  endtask

  task automatic wait_moving();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (state_out == 2'd1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_20);
    end
    chk("wait for MOVING", 32'(seen), 32'd1);
  endtask

  logic [3:0] walk_btn  [6] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0001, 4'b0100};
  int         walk_head [6] = '{5, 0, 1, 2, 3, 4};

  initial begin
    repeat (3) @(negedge clk_20);
    cmp_en = 1'b1;
    chk("reset state", 32'(state_out), 32'd0);
    chk("reset head", 32'(head), 32'd6);
    chk("reset visited", 32'(visited), 32'h40);
    chk("reset seg_n", 32'(seg_n), 32'b0111111);

    // Release with a coincident button pulse, which INITIAL must ignore.
    rst = 1'b0;
    btn_up = 1'b1;
    for (int i = 0; i < INIT; i++) begin
      chk("initial state", 32'(state_out), 32'd0);
      chk("initial seg_n", 32'(seg_n), 32'b0111111);
      @(negedge clk_20);
      btn_up = 1'b0;
    end
    chk("enter moving", 32'(state_out), 32'd1);

    pulse(4'b0100);
    chk("G left head", 32'(head), 32'd5);
    chk("G left visited", 32'(visited), 32'h60);
    @(negedge clk_20);
    chk("F lit seg_n", 32'(seg_n), 32'b0011111);
    @(negedge clk_20);
    chk("F phase0 seg_n", 32'(seg_n), 32'b0011111);
    @(negedge clk_20);
    chk("F blink off seg_n", 32'(seg_n), 32'b0111111);

    pulse(4'b0010);
    chk("F up head", 32'(head), 32'd0);
    pulse(4'b0010);
    chk("A up falls", 32'(state_out), 32'd2);
    chk("A up head holds", 32'(head), 32'd0);
    for (int k = 0; k < FALL; k++) begin
      @(negedge clk_20);
      chk("falling blank", 32'(seg_n), 32'h7F);
    end
    chk("fall to initial", 32'(state_out), 32'd0);
    chk("fall head", 32'(head), 32'd6);
    chk("fall visited", 32'(visited), 32'h40);

    wait_moving();
    pulse(4'b1001);
    chk("right beats down", 32'(head), 32'd1);
    chk("right beats down vis", 32'(visited), 32'h42);
    chk("right beats down st", 32'(state_out), 32'd1);

    pulse(4'b1000);
    chk("B right falls", 32'(state_out), 32'd2);
    wait_moving();
    for (int k = 0; k < 6; k++) begin
      pulse(walk_btn[k]);
      chk("walk head", 32'(head), 32'(walk_head[k]));
    end
    chk("win visited", 32'(visited), 32'h7F);
    chk("win state", 32'(state_out), 32'd3);
    repeat (22) @(negedge clk_20);
    chk("win sticky", 32'(state_out), 32'd3);
    chk("win seg_n", 32'(seg_n), 32'h00);
    pulse(4'b1000);
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b0001);
    chk("win revisit state", 32'(state_out), 32'd3);
    chk("win revisit head", 32'(head), 32'd4);

    rst = 1'b1;
    @(negedge clk_20);
    rst = 1'b0;
    wait_moving();
    pulse(4'b0100);
    pulse(4'b1000);
    chk("revisit falls", 32'(state_out), 32'd2);
    @(negedge clk_20);
    #2 rst = 1'b1;
    #1;
    chk("async rst state", 32'(state_out), 32'd0);
    chk("async rst seg_n", 32'(seg_n), 32'b0111111);
    chk("async rst head", 32'(head), 32'd6);
    @(negedge clk_20);
    rst = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      btn_right = ($urandom_range(0, 5) == 0);
      btn_left  = ($urandom_range(0, 5) == 0);
      btn_up    = ($urandom_range(0, 5) == 0);
      btn_down  = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk_20);
    end
    {btn_right, btn_left, btn_up, btn_down} = 4'b0000;
    rst = 1'b0;
    @(negedge clk_20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
